// File: rtl/eo_noc_pkg.sv
// Shared definitions for the even-odd mesh router: direction encoding, port
// count and the even-odd admissible-direction function.
package eo_noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        DIR_EAST  = 3'd0,
        DIR_WEST  = 3'd1,
        DIR_NORTH = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    localparam logic [NUM_PORTS-1:0] MASK_EAST  = 5'b00001;
    localparam logic [NUM_PORTS-1:0] MASK_WEST  = 5'b00010;
    localparam logic [NUM_PORTS-1:0] MASK_NORTH = 5'b00100;
    localparam logic [NUM_PORTS-1:0] MASK_SOUTH = 5'b01000;
    localparam logic [NUM_PORTS-1:0] MASK_LOCAL = 5'b10000;

    // Even-odd turn model: returns one bit per direction that may be taken.
    function automatic logic [NUM_PORTS-1:0] route_mask(
        input logic [7:0] cur_x,
        input logic [7:0] cur_y,
        input logic [7:0] dest_x,
        input logic [7:0] dest_y,
        input logic [7:0] src_x
    );
        logic [NUM_PORTS-1:0] m;
        logic [NUM_PORTS-1:0] ns;
        m  = 5'b00000;
        ns = (dest_y > cur_y) ? MASK_NORTH : MASK_SOUTH;
        if (dest_x == cur_x) begin
            if (dest_y == cur_y) begin
                m = MASK_LOCAL;
            end else begin
                m = ns;
            end
        end else if (dest_x > cur_x) begin
            if (dest_y == cur_y) begin
                m = MASK_EAST;
            end else begin
                if (cur_x[0] || (cur_x == src_x)) begin
                    m = m | ns;
                end else begin
                    m = m;
                end
                if (dest_x[0] || (dest_x > (cur_x + 8'd1))) begin
                    m = m | MASK_EAST;
                end else begin
                    m = m;
                end
            end
        end else begin
            m = MASK_WEST;
            if (!cur_x[0] && (dest_y != cur_y)) begin
                m = m | ns;
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/eo_flit_fifo.sv
// Input flit buffer: DEPTH entries, extra pointer bit distinguishes full from empty.
module eo_flit_fifo
    import eo_noc_pkg::*;
#(
    parameter int DW    = 38,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/eo_adaptive_router_port.sv
// Single input port of an even-odd mesh router with per-output credit counters.
// Define EO_ADAPTIVE_EN to pick the admissible port with the most credit.
module eo_adaptive_router_port
    import eo_noc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int X_SIZE  = 4,
    parameter int Y_SIZE  = 4,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    parameter int X_BITS  = $clog2(X_SIZE),
    parameter int Y_BITS  = $clog2(Y_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [X_BITS-1:0]    cur_x,
    input  logic [Y_BITS-1:0]    cur_y,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [X_BITS-1:0]    in_dest_x,
    input  logic [Y_BITS-1:0]    in_dest_y,
    input  logic [X_BITS-1:0]    in_src_x,
    input  logic [NUM_PORTS-1:0] credit_ret,
    output logic                 out_valid,
    output logic [2:0]           out_port,
    output logic [WIDTH-1:0]     out_data,
    output logic [X_BITS-1:0]    out_dest_x,
    output logic [Y_BITS-1:0]    out_dest_y,
    output logic [X_BITS-1:0]    out_src_x,
    output logic                 route_err,
    output logic                 credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int FW = WIDTH + 2 * X_BITS + Y_BITS;

    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [FW-1:0]                head_s;
    logic [WIDTH-1:0]             head_data_s;
    logic [X_BITS-1:0]            head_dest_x_s;
    logic [Y_BITS-1:0]            head_dest_y_s;
    logic [X_BITS-1:0]            head_src_x_s;
    logic                         range_err_s;
    logic [NUM_PORTS-1:0]         adm_mask_s;
    logic [2:0]                   sel_port_s;
    logic                         sel_ok_s;
    logic                         issue_s;
    logic [NUM_PORTS-1:0][CW-1:0] credit_r;
    logic [NUM_PORTS-1:0][CW-1:0] credit_nxt_s;
    logic                         credit_err_nxt_s;

    assign in_ready = !fifo_full_s;
    assign issue_s  = !fifo_empty_s && sel_ok_s;

    eo_flit_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data ({in_src_x, in_dest_y, in_dest_x, in_data}),
        .pop     (issue_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign head_data_s   = head_s[WIDTH-1:0];
    assign head_dest_x_s = head_s[WIDTH +: X_BITS];
    assign head_dest_y_s = head_s[WIDTH + X_BITS +: Y_BITS];
    assign head_src_x_s  = head_s[WIDTH + X_BITS + Y_BITS +: X_BITS];

    // Admissible directions for the head flit; off-mesh destinations sink locally
    always_comb begin
        range_err_s = (32'(head_dest_x_s) >= 32'(X_SIZE)) || (32'(head_dest_y_s) >= 32'(Y_SIZE));
        if (range_err_s) begin
            adm_mask_s = MASK_LOCAL;
        end else begin
            adm_mask_s = route_mask(8'(cur_x), 8'(cur_y), 8'(head_dest_x_s),
                                    8'(head_dest_y_s), 8'(head_src_x_s));
        end
    end

`ifdef EO_ADAPTIVE_EN
    // Output selection: most credit wins, earlier direction wins ties
    always_comb begin
        logic [CW-1:0] best_cnt;
        best_cnt   = {CW{1'b0}};
        sel_port_s = DIR_LOCAL;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (adm_mask_s[p] && (credit_r[p] > best_cnt)) begin
                best_cnt   = credit_r[p];
                sel_port_s = 3'(p);
            end else begin
                best_cnt   = best_cnt;
                sel_port_s = sel_port_s;
            end
        end
        sel_ok_s = (best_cnt != {CW{1'b0}});
    end
`else
    // Output selection: first admissible direction, then wait for its credit
    always_comb begin
        logic found;
        found      = 1'b0;
        sel_port_s = DIR_LOCAL;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (adm_mask_s[p] && !found) begin
                found      = 1'b1;
                sel_port_s = 3'(p);
            end else begin
                found      = found;
                sel_port_s = sel_port_s;
            end
        end
        sel_ok_s = (credit_r[sel_port_s] != {CW{1'b0}});
    end
`endif

    // Credit bookkeeping: issue and return in the same cycle cancel out
    always_comb begin
        logic dec;
        credit_nxt_s     = credit_r;
        credit_err_nxt_s = credit_err;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dec = issue_s && (sel_port_s == 3'(p));
            if (credit_ret[p] && !dec) begin
                if (credit_r[p] == CW'(CREDITS)) begin
                    credit_err_nxt_s = 1'b1;
                end else begin
                    credit_nxt_s[p] = credit_r[p] + CW'(1);
                end
            end else if (dec && !credit_ret[p]) begin
                credit_nxt_s[p] = credit_r[p] - CW'(1);
            end else begin
                credit_nxt_s[p] = credit_r[p];
            end
        end
    end

    // Credit counter and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r   <= {NUM_PORTS{CW'(CREDITS)}};
            credit_err <= 1'b0;
        end else begin
            credit_r   <= credit_nxt_s;
            credit_err <= credit_err_nxt_s;
        end
    end

    // Issued-flit output registers; fields hold between issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_port   <= DIR_LOCAL;
            out_data   <= {WIDTH{1'b0}};
            out_dest_x <= {X_BITS{1'b0}};
            out_dest_y <= {Y_BITS{1'b0}};
            out_src_x  <= {X_BITS{1'b0}};
            route_err  <= 1'b0;
        end else begin
            out_valid <= issue_s;
            route_err <= issue_s && range_err_s;
            if (issue_s) begin
                out_port   <= sel_port_s;
                out_data   <= head_data_s;
                out_dest_x <= head_dest_x_s;
                out_dest_y <= head_dest_y_s;
                out_src_x  <= head_src_x_s;
            end else begin
                out_port   <= out_port;
                out_data   <= out_data;
                out_dest_x <= out_dest_x;
                out_dest_y <= out_dest_y;
                out_src_x  <= out_src_x;
            end
        end
    end

endmodule
